mole_game_ctrl: RTL and testbench
=================================

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 SHALL have parameter MOLE_TICKS, default 750, tick strobes a mole stays visible.
REQ-002 SHALL have parameter GAP_TICKS, default 250, tick strobes between moles.
REQ-003 SHALL have parameter ROUNDS, default 30, moles per game (1..255).
REQ-004 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, asynchronous, active-low.
REQ-006 SHALL have port tick  in  1  one-cycle timebase strobe (nominally 1 ms).
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a game.
REQ-008 SHALL have port btn_valid  in  1  one-cycle pulse, debounced button press.
REQ-009 SHALL have port btn_pos  in  3  pressed slot (0 top, 1 left, 2 center, 3 right, 4 bottom); sampled only with btn_valid.
REQ-010 SHALL have port mole_position  out  3  current mole slot, same encoding as btn_pos.
REQ-011 SHALL have port mole_visible  out  1  high while a mole is shown.
REQ-012 SHALL have port guess_correct  out  1  one-cycle hit pulse.
REQ-013 SHALL have port guess_wrong  out  1  one-cycle miss/wrong pulse.
REQ-014 SHALL have ports digit_1 / digit_2  out  4 each  score BCD tens / units.
REQ-015 SHALL have port game_over  out  1  high in DONE.

Function
REQ-016 SHALL implement states IDLE, GAP, SHOW, DONE; all outputs registered.
REQ-017 SHALL move IDLE->GAP and DONE->GAP on start, clearing score, round count and tick counter; start in GAP/SHOW SHALL be ignored.
REQ-018 SHALL count tick strobes in GAP; after GAP_TICKS strobes, load a new position, set mole_visible, enter SHOW.
REQ-019 SHALL run an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advancing every clk; new position = lfsr[2:0] mapped 5->0, 6->1, 7->2; if equal to previous position, add 1 modulo 5.
REQ-020 SHALL, in SHOW, on btn_valid with btn_pos == mole_position: pulse guess_correct next cycle, score +1, clear mole_visible, go GAP.
REQ-021 SHALL, in SHOW, on btn_valid with any other btn_pos (including 5..7): pulse guess_wrong next cycle and stay in SHOW with timer unchanged.
REQ-022 SHALL, in SHOW, after MOLE_TICKS strobes without a hit: pulse guess_wrong, clear mole_visible, go GAP.
REQ-023 SHALL give btn_valid priority over a same-cycle timeout.
REQ-024 SHALL ignore btn_valid in IDLE, GAP and DONE (no pulse).
REQ-025 SHALL increment the round count on every SHOW exit; when it reaches ROUNDS, go DONE instead of GAP; game_over=1, mole_visible=0 in DONE.
REQ-026 SHALL keep score as two BCD digits, units wrap 9->0 carrying into tens; saturate at 99.
REQ-027 SHALL never assert guess_correct and guess_wrong in the same cycle.

Reset
REQ-028 SHALL, on rst low, force IDLE, mole_position=0, mole_visible=0, guess_correct=0, guess_wrong=0, digit_1=0, digit_2=0, game_over=0, counters 0, LFSR 8'hA5, regardless of clk.
REQ-029 SHALL, on reset mid-game, abandon the game with no pulses emitted; first post-reset action requires start.

Configuration
REQ-030 SHALL support macro MOLE_MISS_PENALTY_EN: defined -> every guess_wrong decrements score by 1 in BCD, saturating at 00; undefined -> guess_wrong leaves score unchanged.

Verification (MOLE_TICKS=4, GAP_TICKS=2, ROUNDS=3, tick every clk)
REQ-031 SHALL check reset: rst low mid-SHOW -> all outputs 0, IDLE; btn_valid afterwards -> no pulse.
REQ-032 SHALL check hit: start, wait mole_visible, btn_pos=mole_position -> guess_correct one cycle, digits 0/1, mole_visible low.
REQ-033 SHALL check wrong then hit: btn_pos=(pos+1)%5 -> guess_wrong, mole stays; then correct press -> guess_correct, score 01 (00 with MOLE_MISS_PENALTY_EN then hit -> 01).
REQ-034 SHALL check timeout plus collision: no press -> guess_wrong after 4 ticks; correct press in timeout cycle -> guess_correct only.
REQ-035 SHALL check game end: 3 rounds -> game_over=1, positions never repeat consecutively, btn ignored; start -> score 00, GAP.
REQ-036 SHALL check BCD: preload score 09 then hit -> 10; 99 then hit -> 99.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole game sequencer.
// A game is a fixed number of rounds. Each round waits GAP_TICKS timebase
// strobes, then shows a mole at a pseudo-random slot for up to MOLE_TICKS
// strobes. A press on the mole's slot scores a hit; a press elsewhere, or
// letting the mole time out, signals a wrong guess. Score is kept as two BCD
// digits and saturates at 99.
// Optional feature macro: MOLE_MISS_PENALTY_EN -- when defined, every
// guess_wrong pulse also takes one point off the score (never below 00).
// Reset (rst) is asynchronous and active-low.

module mole_game_ctrl #(
    parameter int unsigned MOLE_TICKS = 750,
    parameter int unsigned GAP_TICKS  = 250,
    parameter int unsigned ROUNDS     = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [2:0] btn_pos,
    output logic [2:0] mole_position,
    output logic       mole_visible,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic       game_over
);

    // The tick counter only ever has to reach the larger of the two windows.
    localparam int unsigned MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int unsigned CW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);

    localparam logic [CW-1:0] MOLE_LAST  = CW'(MOLE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
    localparam logic [8:0]    ROUND_LAST = 9'(ROUNDS);
    localparam logic [7:0]    LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    round_q, round_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [2:0]    mole_position_q, mole_position_d;
    logic          mole_visible_q, mole_visible_d;
    logic          guess_correct_q, guess_correct_d;
    logic          guess_wrong_q, guess_wrong_d;
    logic          game_over_q, game_over_d;

    logic          hit_s;
    logic          wrong_press_s;
    logic          timeout_s;
    logic          gap_done_s;
    logic          show_exit_s;
    logic          last_round_s;
    logic [2:0]    new_pos_s;
    logic [7:0]    score_hit_s;
    logic [7:0]    score_miss_s;

    // BCD +1 on a two-digit score, holding at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD -1 on a two-digit score, holding at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Fold the 3-bit random value onto the five slots and avoid showing the
    // mole twice in a row at the same slot.
    function automatic logic [2:0] pick_pos(input logic [2:0] raw, input logic [2:0] prev);
        logic [2:0] m;
        if (raw >= 3'd5) begin
            m = raw - 3'd5;
        end else begin
            m = raw;
        end
        if (m == prev) begin
            if (m == 3'd4) begin
                m = 3'd0;
            end else begin
                m = m + 3'd1;
            end
        end else begin
            m = m;
        end
        return m;
    endfunction

    assign score_hit_s = bcd_inc(score_q);
`ifdef MOLE_MISS_PENALTY_EN
    assign score_miss_s = bcd_dec(score_q);
`else
    assign score_miss_s = score_q;
`endif

    // Decode the events of the current cycle; a press always wins over a timeout.
    always_comb begin
        hit_s         = (state_q == S_SHOW) && btn_valid && (btn_pos == mole_position_q);
        wrong_press_s = (state_q == S_SHOW) && btn_valid && (btn_pos != mole_position_q);
        timeout_s     = (state_q == S_SHOW) && !btn_valid && tick && (tick_cnt_q == MOLE_LAST);
        gap_done_s    = (state_q == S_GAP) && tick && (tick_cnt_q == GAP_LAST);
        show_exit_s   = hit_s || timeout_s;
        last_round_s  = ({1'b0, round_q} + 9'd1) == ROUND_LAST;
        new_pos_s     = pick_pos(lfsr_q[2:0], mole_position_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_GAP;
                end else begin
                    state_d = state_q;
                end
            end
            S_GAP: begin
                if (gap_done_s) begin
                    state_d = S_SHOW;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_SHOW: begin
                if (show_exit_s) begin
                    state_d = last_round_s ? S_DONE : S_GAP;
                end else begin
                    state_d = S_SHOW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; pulses default low every cycle.
    always_comb begin
        tick_cnt_d      = tick_cnt_q;
        round_d         = round_q;
        score_d         = score_q;
        mole_position_d = mole_position_q;
        mole_visible_d  = mole_visible_q;
        game_over_d     = game_over_q;
        guess_correct_d = 1'b0;
        guess_wrong_d   = 1'b0;
        lfsr_d          = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    tick_cnt_d     = '0;
                    round_d        = 8'd0;
                    score_d        = 8'h00;
                    mole_visible_d = 1'b0;
                    game_over_d    = 1'b0;
                end else begin
                    mole_visible_d = 1'b0;
                end
            end
            S_GAP: begin
                if (gap_done_s) begin
                    tick_cnt_d      = '0;
                    mole_position_d = new_pos_s;
                    mole_visible_d  = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            S_SHOW: begin
                if (hit_s) begin
                    guess_correct_d = 1'b1;
                    score_d         = score_hit_s;
                    mole_visible_d  = 1'b0;
                    tick_cnt_d      = '0;
                    round_d         = round_q + 8'd1;
                    game_over_d     = last_round_s;
                end else if (wrong_press_s) begin
                    guess_wrong_d = 1'b1;
                    score_d       = score_miss_s;
                end else if (timeout_s) begin
                    guess_wrong_d  = 1'b1;
                    score_d        = score_miss_s;
                    mole_visible_d = 1'b0;
                    tick_cnt_d     = '0;
                    round_d        = round_q + 8'd1;
                    game_over_d    = last_round_s;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                tick_cnt_d      = '0;
                round_d         = 8'd0;
                score_d         = 8'h00;
                mole_position_d = 3'd0;
                mole_visible_d  = 1'b0;
                game_over_d     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q      <= '0;
            round_q         <= 8'd0;
            score_q         <= 8'h00;
            lfsr_q          <= LFSR_SEED;
            mole_position_q <= 3'd0;
            mole_visible_q  <= 1'b0;
            guess_correct_q <= 1'b0;
            guess_wrong_q   <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            tick_cnt_q      <= tick_cnt_d;
            round_q         <= round_d;
            score_q         <= score_d;
            lfsr_q          <= lfsr_d;
            mole_position_q <= mole_position_d;
            mole_visible_q  <= mole_visible_d;
            guess_correct_q <= guess_correct_d;
            guess_wrong_q   <= guess_wrong_d;
            game_over_q     <= game_over_d;
        end
    end

    assign mole_position = mole_position_q;
    assign mole_visible  = mole_visible_q;
    assign guess_correct = guess_correct_q;
    assign guess_wrong   = guess_wrong_q;
    assign digit_1       = score_q[7:4];
    assign digit_2       = score_q[3:0];
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl. Instance A (4/2/3) covers reset, hit, wrong,
// timeout, press/timeout collision and game end; instance B (4/2/100) plays
// 100 straight hits to cover BCD carry and saturation at 99.
// Expected pulses are queued by the stimulus and checked by per-instance monitors.

module tb_mole_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick;
    logic       start_a, bv_a, start_b, bv_b;
    logic [2:0] bp_a, bp_b;
    logic [2:0] pos_a, pos_b;
    logic       vis_a, gc_a, gw_a, go_a, vis_b, gc_b, gw_b, go_b;
    logic [3:0] d1_a, d2_a, d1_b, d2_b;

    mole_game_ctrl #(.MOLE_TICKS(4), .GAP_TICKS(2), .ROUNDS(3)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start_a),
        .btn_valid(bv_a), .btn_pos(bp_a),
        .mole_position(pos_a), .mole_visible(vis_a),
        .guess_correct(gc_a), .guess_wrong(gw_a),
        .digit_1(d1_a), .digit_2(d2_a), .game_over(go_a)
    );

    mole_game_ctrl #(.MOLE_TICKS(4), .GAP_TICKS(2), .ROUNDS(100)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start_b),
        .btn_valid(bv_b), .btn_pos(bp_b),
        .mole_position(pos_b), .mole_visible(vis_b),
        .guess_correct(gc_b), .guess_wrong(gw_b),
        .digit_1(d1_b), .digit_2(d2_b), .game_over(go_b)
    );

    typedef struct packed {
        logic       correct;
        logic [3:0] d1;
        logic [3:0] d2;
        logic       vis;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] last_pos_a = 3'd0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic exp_t mk(input logic c, input int s, input logic v);
        exp_t e;
        e.correct = c;
        e.d1      = 4'(s / 10);
        e.d2      = 4'(s % 10);
        e.vis     = v;
        return e;
    endfunction

    function automatic int miss(input int s);
`ifdef MOLE_MISS_PENALTY_EN
        return (s > 0) ? s - 1 : 0;
`else
        return s;
`endif
    endfunction

    function automatic int hit(input int s);
        return (s < 99) ? s + 1 : 99;
    endfunction

    // Monitor A: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (gc_a || gw_a) begin
            check("a_pulse_exclusive", int'(gc_a & gw_a), 0);
            if (qa.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected_pulse: got correct=%0b wrong=%0b expected no pulse", gc_a, gw_a);
            end else begin
                e = qa.pop_front();
                check("a_response{c,d1,d2,vis}", int'({gc_a, d1_a, d2_a, vis_a}), int'(e));
            end
        end
    end

    // Monitor B: same comparison for the long game.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (gc_b || gw_b) begin
            if (qb.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_pulse: got correct=%0b wrong=%0b expected no pulse", gc_b, gw_b);
            end else begin
                e = qb.pop_front();
                check("b_response{c,d1,d2,vis}", int'({gc_b, d1_b, d2_b, vis_b}), int'(e));
            end
        end
    end

    task automatic wait_vis_a(output logic [2:0] p);
        int n = 0;
        while (!vis_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_mole_shown", int'(vis_a), 1);
        p = pos_a;
        check("a_pos_in_range", int'(pos_a < 3'd5), 1);
        check("a_pos_no_repeat", int'(pos_a != last_pos_a), 1);
        last_pos_a = pos_a;
    endtask

    task automatic wait_pulse_a();
        int n = 0;
        while (!(gc_a || gw_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a_pulse_seen", int'(gc_a | gw_a), 1);
    endtask

    task automatic press_a(input logic [2:0] p);
        bp_a = p;
        bv_a = 1'b1;
        @(negedge clk);
        bv_a = 1'b0;
        bp_a = 3'd0;
    endtask

    task automatic start_game_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_pos"}, int'(pos_a), 0);
        check({tag, "_vis"}, int'(vis_a), 0);
        check({tag, "_gc"}, int'(gc_a), 0);
        check({tag, "_gw"}, int'(gw_a), 0);
        check({tag, "_d1"}, int'(d1_a), 0);
        check({tag, "_d2"}, int'(d2_a), 0);
        check({tag, "_go"}, int'(go_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] p;
        int         sa;
        int         n;
        rst = 1'b0; tick = 1'b1;
        start_a = 1'b0; bv_a = 1'b0; bp_a = 3'd0;
        start_b = 1'b0; bv_b = 1'b0; bp_b = 3'd0;
        sa = 0;
        repeat (2) @(negedge clk);
        check_all_zero_a("rst_init");
        rst = 1'b1;
        @(negedge clk);

        // Game 1: hit, wrong-then-hit, timeout into DONE.
        start_game_a();
        check("a_vis_in_gap", int'(vis_a), 0);
        wait_vis_a(p);
        sa = hit(sa);
        qa.push_back(mk(1'b1, sa, 1'b0));
        press_a(p);

        wait_vis_a(p);
        sa = miss(sa);
        qa.push_back(mk(1'b0, sa, 1'b1));
        press_a(3'((int'(p) + 1) % 5));
        sa = hit(sa);
        qa.push_back(mk(1'b1, sa, 1'b0));
        press_a(p);

        wait_vis_a(p);
        sa = miss(sa);
        qa.push_back(mk(1'b0, sa, 1'b0));
        wait_pulse_a();
        check("a_game_over_set", int'(go_a), 1);
        press_a(p);
        repeat (3) @(negedge clk);
        check("a_game_over_hold", int'(go_a), 1);
        check("a_vis_in_done", int'(vis_a), 0);

        // Restart from DONE clears score and game_over.
        start_game_a();
        sa = 0;
        check("a_restart_go", int'(go_a), 0);
        check("a_restart_d1", int'(d1_a), 0);
        check("a_restart_d2", int'(d2_a), 0);
        check("a_restart_vis", int'(vis_a), 0);

        // Game 2: press in the timeout cycle, out-of-range press, timeout, hit.
        wait_vis_a(p);
        sa = hit(sa);
        qa.push_back(mk(1'b1, sa, 1'b0));
        repeat (3) @(negedge clk);
        press_a(p);

        wait_vis_a(p);
        sa = miss(sa);
        qa.push_back(mk(1'b0, sa, 1'b1));
        press_a(3'd7);
        sa = miss(sa);
        qa.push_back(mk(1'b0, sa, 1'b0));
        @(negedge clk);
        wait_pulse_a();

        wait_vis_a(p);
        sa = hit(sa);
        qa.push_back(mk(1'b1, sa, 1'b0));
        press_a(p);
        check("a_game2_over", int'(go_a), 1);

        // Game 3: score a point, then reset while the next mole is shown.
        start_game_a();
        sa = 0;
        wait_vis_a(p);
        sa = hit(sa);
        qa.push_back(mk(1'b1, sa, 1'b0));
        press_a(p);
        wait_vis_a(p);
        rst = 1'b0;
        #1;
        check_all_zero_a("rst_mid_show");
        @(negedge clk);
        rst = 1'b1;
        last_pos_a = 3'd0;
        @(negedge clk);
        press_a(p);
        repeat (4) @(negedge clk);
        check("a_idle_after_rst_vis", int'(vis_a), 0);
        check("a_idle_after_rst_go", int'(go_a), 0);

        // Instance B: 100 hits walk the score through every carry up to 99.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            n = 0;
            while (!vis_b && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b_mole_shown", int'(vis_b), 1);
            qb.push_back(mk(1'b1, (k > 99) ? 99 : k, 1'b0));
            bp_b = pos_b;
            bv_b = 1'b1;
            @(negedge clk);
            bv_b = 1'b0;
        end
        check("b_game_over", int'(go_b), 1);
        check("b_final_d1", int'(d1_b), 9);
        check("b_final_d2", int'(d2_b), 9);

        repeat (4) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
